// File: rtl/lru_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lru_alloc_pkg
// Purpose  : Shared constants and enumerations for the LRU way allocator
//            (tag table geometry, controller states, request opcodes).
// Revision : 1.0 - initial release
// ============================================================================
package lru_alloc_pkg;

  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = 2;

  // Controller states: accept, single-cycle table access, response hold.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request opcodes as carried on req_op_i.
  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INVAL  = 1'b1
  } op_t;

endpackage : lru_alloc_pkg
`default_nettype wire

// File: rtl/lru_tag_match.sv
`default_nettype none
// ============================================================================
// Module   : lru_tag_match
// Purpose  : Combinational 4-way tag comparator for the allocator's tag
//            table. Reports a hit and its encoded way, plus whether any way
//            is free and the lowest-numbered free way.
// Ports    : valid       - per-way valid bits
//            tags        - per-way stored tags
//            tag         - tag being searched for
//            hit         - some valid way holds tag
//            hit_way     - encoded index of the matching way
//            any_invalid - at least one way is free
//            inv_way     - lowest-numbered free way
// Revision : 1.0 - initial release
// ============================================================================
module lru_tag_match
  import lru_alloc_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic [NUM_WAYS-1:0]            valid,
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]               tag,
  output logic                           hit,
  output logic [WAY_W-1:0]               hit_way,
  output logic                           any_invalid,
  output logic [WAY_W-1:0]               inv_way
);

  logic [NUM_WAYS-1:0] w_match;

  generate
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way_cmp
      assign w_match[g] = valid[g] && (tags[g] == tag);
    end
  endgenerate

  assign hit         = |w_match;
  assign any_invalid = ~&valid;

  // The table never holds a tag twice, so w_match is at most one-hot and an
  // OR of the matching indices is a valid encoding.
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_match[i]) begin
        hit_way = hit_way | WAY_W'(i);
      end
    end
  end

  // Scan from the top down so the lowest-numbered free way wins.
  always_comb begin
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        inv_way = WAY_W'(i);
      end
    end
  end

endmodule : lru_tag_match
`default_nettype wire

// File: rtl/lru_way_allocator.sv
`default_nettype none
// ============================================================================
// Module   : lru_way_allocator
// Purpose  : Client-side controller for a 4-entry LRU tracker. Holds a fully
//            associative tag table, serves lookup/allocate and invalidate
//            requests over a valid/ready handshake, and strobes the tracker
//            so its ages follow every table access.
// Ports    : clk, rst_n           - clock, async active-low reset
//            req_valid_i/ready_o  - request handshake
//            req_op_i, req_tag_i  - opcode (0 lookup, 1 invalidate) and tag
//            rsp_valid_o/ready_i  - response handshake
//            rsp_hit_o, rsp_way_o - hit flag and way touched
//            rsp_evict_valid_o/
//            rsp_evict_tag_o      - overwritten entry, if any
//            lru_index_o          - way index to the tracker
//            lru_access_o         - tracker access strobe (mark MRU)
//            lru_update_o         - tracker update strobe (way freed)
//            lru_victim_i         - tracker's current LRU way
// Revision : 1.0 - initial release
// ============================================================================
module lru_way_allocator
  import lru_alloc_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [WAY_W-1:0] rsp_way_o,
  output logic             rsp_evict_valid_o,
  output logic [TAG_W-1:0] rsp_evict_tag_o,
  output logic [WAY_W-1:0] lru_index_o,
  output logic             lru_access_o,
  output logic             lru_update_o,
  input  logic [WAY_W-1:0] lru_victim_i
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                         r_state;
  state_t                         w_state_nxt;
  op_t                            r_op;
  logic [TAG_W-1:0]               r_tag;
  logic [NUM_WAYS-1:0]            r_valid;
  logic [NUM_WAYS-1:0][TAG_W-1:0] r_tags;

  logic                           r_rsp_hit;
  logic [WAY_W-1:0]               r_rsp_way;
  logic                           r_rsp_evict_valid;
  logic [TAG_W-1:0]               r_rsp_evict_tag;

  // --------------------------------------------------------------------------
  // Combinational controls
  // --------------------------------------------------------------------------
  logic                           w_hit;
  logic [WAY_W-1:0]               w_hit_way;
  logic                           w_any_invalid;
  logic [WAY_W-1:0]               w_inv_way;

  logic                           w_accept;
  logic                           w_rsp_load;
  logic                           w_tbl_write;
  logic                           w_tbl_clear;
  logic [WAY_W-1:0]               w_tbl_way;
  logic                           w_rsp_hit_nxt;
  logic [WAY_W-1:0]               w_rsp_way_nxt;
  logic                           w_evict_valid_nxt;
  logic [TAG_W-1:0]               w_evict_tag_nxt;

  lru_tag_match #(
    .TAG_W (TAG_W)
  ) u_tag_match (
    .valid       (r_valid),
    .tags        (r_tags),
    .tag         (r_tag),
    .hit         (w_hit),
    .hit_way     (w_hit_way),
    .any_invalid (w_any_invalid),
    .inv_way     (w_inv_way)
  );

  // Next-state and outputs. Table access and tracker strobes happen only in
  // the single LOOKUP cycle; the response is captured there and replayed
  // from registers while RESP waits for the consumer.
  always_comb begin
    w_state_nxt       = r_state;
    req_ready_o       = 1'b0;
    w_accept          = 1'b0;
    w_rsp_load        = 1'b0;
    w_tbl_write       = 1'b0;
    w_tbl_clear       = 1'b0;
    w_tbl_way         = '0;
    w_rsp_hit_nxt     = 1'b0;
    w_rsp_way_nxt     = '0;
    w_evict_valid_nxt = 1'b0;
    w_evict_tag_nxt   = '0;
    lru_access_o      = 1'b0;
    lru_update_o      = 1'b0;
    lru_index_o       = '0;

    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = LOOKUP;
        end
      end

      LOOKUP: begin
        w_rsp_load  = 1'b1;
        w_state_nxt = RESP;
        if (r_op == OP_LOOKUP) begin
          lru_access_o = 1'b1;
          if (w_hit) begin
            w_rsp_hit_nxt = 1'b1;
            w_rsp_way_nxt = w_hit_way;
          end else if (w_any_invalid) begin
            // A free way is always preferred over evicting a live entry.
            w_tbl_write   = 1'b1;
            w_rsp_way_nxt = w_inv_way;
          end else begin
            // Table full: the tracker's victim is sampled in this cycle.
            w_tbl_write       = 1'b1;
            w_rsp_way_nxt     = lru_victim_i;
            w_evict_valid_nxt = 1'b1;
            w_evict_tag_nxt   = r_tags[lru_victim_i];
          end
          w_tbl_way   = w_rsp_way_nxt;
          lru_index_o = w_rsp_way_nxt;
        end else if (w_hit) begin
          w_rsp_hit_nxt = 1'b1;
          w_rsp_way_nxt = w_hit_way;
          w_tbl_clear   = 1'b1;
          w_tbl_way     = w_hit_way;
          lru_update_o  = 1'b1;
          lru_index_o   = w_hit_way;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_op              <= OP_LOOKUP;
      r_tag             <= '0;
      r_valid           <= '0;
      r_tags            <= '0;
      r_rsp_hit         <= 1'b0;
      r_rsp_way         <= '0;
      r_rsp_evict_valid <= 1'b0;
      r_rsp_evict_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_op  <= op_t'(req_op_i);
        r_tag <= req_tag_i;
      end

      if (w_tbl_write) begin
        r_tags[w_tbl_way]  <= r_tag;
        r_valid[w_tbl_way] <= 1'b1;
      end else if (w_tbl_clear) begin
        r_valid[w_tbl_way] <= 1'b0;
      end

      if (w_rsp_load) begin
        r_rsp_hit         <= w_rsp_hit_nxt;
        r_rsp_way         <= w_rsp_way_nxt;
        r_rsp_evict_valid <= w_evict_valid_nxt;
        r_rsp_evict_tag   <= w_evict_tag_nxt;
      end
    end
  end

  assign rsp_valid_o       = (r_state == RESP);
  assign rsp_hit_o         = r_rsp_hit;
  assign rsp_way_o         = r_rsp_way;
  assign rsp_evict_valid_o = r_rsp_evict_valid;
  assign rsp_evict_tag_o   = r_rsp_evict_tag;

endmodule : lru_way_allocator
`default_nettype wire

// File: tb/tb_lru_way_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lru_way_allocator
// Purpose  : Self-checking bench for lru_way_allocator. Directed vector table
//            for the allocate/hit/evict/invalidate flow, hand sequences for
//            backpressure and mid-response reset, then random traffic
//            checked against an array-based table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lru_way_allocator;

  localparam int TAG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_op_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_hit_o;
  logic [1:0]       rsp_way_o;
  logic             rsp_evict_valid_o;
  logic [TAG_W-1:0] rsp_evict_tag_o;
  logic [1:0]       lru_index_o;
  logic             lru_access_o;
  logic             lru_update_o;
  logic [1:0]       lru_victim_i;

  lru_way_allocator #(
    .TAG_W (TAG_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_tag_i         (req_tag_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_hit_o         (rsp_hit_o),
    .rsp_way_o         (rsp_way_o),
    .rsp_evict_valid_o (rsp_evict_valid_o),
    .rsp_evict_tag_o   (rsp_evict_tag_o),
    .lru_index_o       (lru_index_o),
    .lru_access_o      (lru_access_o),
    .lru_update_o      (lru_update_o),
    .lru_victim_i      (lru_victim_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a plain array of {valid, tag} entries.
  // --------------------------------------------------------------------------
  bit       m_valid [4];
  bit [7:0] m_tag   [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
    end
  endtask

  task automatic model_step(input bit op, input bit [7:0] tag, input bit [1:0] victim,
                            output bit hit, output bit [1:0] way, output bit ev,
                            output bit [7:0] evtag, output bit acc, output bit upd,
                            output bit [1:0] idx);
    int found = -1;
    int free  = -1;
    hit = 0; way = 0; ev = 0; evtag = 0; acc = 0; upd = 0; idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_tag[i] == tag) found = i;
      if (!m_valid[i] && free < 0) free = i;
    end
    if (op == 1'b0) begin
      acc = 1;
      if (found >= 0) begin
        hit = 1;
        way = 2'(found);
      end else begin
        if (free >= 0) begin
          way = 2'(free);
        end else begin
          way   = victim;
          ev    = 1;
          evtag = m_tag[victim];
        end
        m_valid[way] = 1;
        m_tag[way]   = tag;
      end
      idx = way;
    end else if (found >= 0) begin
      hit = 1;
      way = 2'(found);
      upd = 1;
      idx = way;
      m_valid[found] = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Handshake helpers
  // --------------------------------------------------------------------------
  task automatic send(input bit op, input bit [7:0] tag, input bit [1:0] victim);
    int waited = 0;
    @(negedge clk);
    while (!req_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) chk("req_ready_timeout", 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_op_i     = op;
    req_tag_i    = tag;
    lru_victim_i = victim;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic check_lookup(input bit acc, input bit upd, input bit [1:0] idx);
    @(negedge clk);
    chk("lookup_req_ready", 32'(req_ready_o), 32'd0);
    chk("lookup_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("lru_access", 32'(lru_access_o), 32'(acc));
    chk("lru_update", 32'(lru_update_o), 32'(upd));
    chk("lru_index", 32'(lru_index_o), 32'(idx));
  endtask

  task automatic check_resp(input bit hit, input bit [1:0] way, input bit ev,
                            input bit [7:0] evtag, input int hold);
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_hit", 32'(rsp_hit_o), 32'(hit));
      chk("rsp_way", 32'(rsp_way_o), 32'(way));
      chk("rsp_evict_valid", 32'(rsp_evict_valid_o), 32'(ev));
      chk("rsp_evict_tag", 32'(rsp_evict_tag_o), 32'(evtag));
      chk("resp_req_ready", 32'(req_ready_o), 32'd0);
      chk("resp_no_strobe", 32'({lru_access_o, lru_update_o, lru_index_o}), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
  endtask

  task automatic run_txn(input bit op, input bit [7:0] tag, input bit [1:0] victim,
                         input bit hit, input bit [1:0] way, input bit ev,
                         input bit [7:0] evtag, input bit acc, input bit upd,
                         input bit [1:0] idx, input int hold);
    send(op, tag, victim);
    check_lookup(acc, upd, idx);
    check_resp(hit, way, ev, evtag, hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit       op;
    bit [7:0] tag;
    bit [1:0] victim;
    bit       hit;
    bit [1:0] way;
    bit       ev;
    bit [7:0] evtag;
    bit       acc;
    bit       upd;
    bit [1:0] idx;
  } vec_t;

  vec_t vecs[10];

  bit       e_hit, e_ev, e_acc, e_upd;
  bit [1:0] e_way, e_idx;
  bit [7:0] e_evtag;

  initial begin
    //            op    tag    vic   hit   way   ev    evtag  acc   upd   idx
    vecs[0] = '{1'b0, 8'h11, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 8'h22, 2'd3, 1'b0, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{1'b0, 8'h33, 2'd3, 1'b0, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2};
    vecs[3] = '{1'b0, 8'h44, 2'd0, 1'b0, 2'd3, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3};
    vecs[4] = '{1'b0, 8'h22, 2'd0, 1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1};
    vecs[5] = '{1'b0, 8'h55, 2'd2, 1'b0, 2'd2, 1'b1, 8'h33, 1'b1, 1'b0, 2'd2};
    vecs[6] = '{1'b0, 8'h33, 2'd3, 1'b0, 2'd3, 1'b1, 8'h44, 1'b1, 1'b0, 2'd3};
    vecs[7] = '{1'b1, 8'h11, 2'd1, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
    vecs[8] = '{1'b0, 8'h66, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};
    vecs[9] = '{1'b1, 8'h99, 2'd2, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};

    req_valid_i  = 1'b0;
    req_op_i     = 1'b0;
    req_tag_i    = '0;
    rsp_ready_i  = 1'b0;
    lru_victim_i = '0;

    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_hit_o, rsp_way_o, rsp_evict_valid_o, rsp_evict_tag_o}), 32'd0);
    chk("rst_lru", 32'({lru_access_o, lru_update_o, lru_index_o}), 32'd0);

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      model_step(vecs[v].op, vecs[v].tag, vecs[v].victim,
                 e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx);
      run_txn(vecs[v].op, vecs[v].tag, vecs[v].victim, vecs[v].hit, vecs[v].way,
              vecs[v].ev, vecs[v].evtag, vecs[v].acc, vecs[v].upd, vecs[v].idx, 0);
    end

    // Backpressure: response held 5 extra cycles while a second request waits.
    // Table is {66, 22, 55, 33}.
    model_step(1'b0, 8'h66, 2'd1, e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx);
    send(1'b0, 8'h66, 2'd1);
    check_lookup(1'b1, 1'b0, 2'd0);
    req_valid_i  = 1'b1;
    req_op_i     = 1'b0;
    req_tag_i    = 8'h22;
    check_resp(1'b1, 2'd0, 1'b0, 8'h00, 5);
    @(negedge clk);
    chk("pending_ready_in_idle", 32'(req_ready_o), 32'd1);
    chk("pending_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    model_step(1'b0, 8'h22, 2'd0, e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx);
    check_lookup(1'b1, 1'b0, 2'd1);
    check_resp(1'b1, 2'd1, 1'b0, 8'h00, 0);

    // Reset while a response is pending.
    send(1'b0, 8'h77, 2'd2);
    check_lookup(1'b1, 1'b0, 2'd2);
    @(negedge clk);
    chk("pre_reset_rsp_valid", 32'(rsp_valid_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("async_reset_rsp_fields", 32'({rsp_hit_o, rsp_way_o, rsp_evict_valid_o, rsp_evict_tag_o}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // All ways cleared: 0x66 must miss and land in way 0 despite victim 3.
    model_step(1'b0, 8'h66, 2'd3, e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx);
    run_txn(1'b0, 8'h66, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      bit       r_op;
      bit [7:0] r_tag;
      bit [1:0] r_vic;
      int       r_hold;
      r_op   = ($urandom_range(0, 3) == 0);
      r_tag  = 8'($urandom_range(16, 22));
      r_vic  = 2'($urandom_range(0, 3));
      r_hold = $urandom_range(0, 2);
      model_step(r_op, r_tag, r_vic, e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx);
      run_txn(r_op, r_tag, r_vic, e_hit, e_way, e_ev, e_evtag, e_acc, e_upd, e_idx, r_hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lru_way_allocator
`default_nettype wire

// File: doc/lru_way_allocator.md
Name: lru_way_allocator

Overview:
- Client-side controller for the 4-element LRU tracker: a 4-entry, fully associative tag table with a request/response handshake.
- On each request it:
  - looks up a tag;
  - on a miss, chooses a way, taking the tracker's victim index when all ways are valid;
  - installs the new tag;
  - drives the tracker's access/update strobes so LRU ages stay coherent.
- Sits between a requester (TLB/cache-tag style client) and the LRU tracker instance.

Parameters:
- TAG_W, 8, width of stored and requested tags.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request accepted when valid & ready.
- req_op_i  input  1  0 = lookup/allocate, 1 = invalidate.
- req_tag_i  input  TAG_W  tag to look up or invalidate.
- rsp_valid_o  output  1  response present; held until accepted.
- rsp_ready_i  input  1  response consumed when valid & ready.
- rsp_hit_o  output  1  tag was found.
- rsp_way_o  output  2  way hit, allocated, or invalidated.
- rsp_evict_valid_o  output  1  a valid entry was overwritten.
- rsp_evict_tag_o  output  TAG_W  tag of the overwritten entry.
- lru_index_o  output  2  index to tracker.
- lru_access_o  output  1  one-cycle access strobe to tracker.
- lru_update_o  output  1  one-cycle update strobe to tracker.
- lru_victim_i  input  2  tracker's least-recently-used index.

Behaviour:
- State per way: valid bit and TAG_W tag.
- FSM states are IDLE, LOOKUP and RESP.
- IDLE:
  - req_ready_o = 1, combinational from state.
  - On valid & ready, register op and tag, then go to LOOKUP.
- LOOKUP (exactly one cycle, req_ready_o = 0). Compare the registered tag against all valid ways; at most one can match.
  - op = 0, hit:
    - rsp_hit = 1, rsp_way = matching way, evict_valid = 0.
    - lru_access_o = 1, lru_index_o = way.
  - op = 0, miss with some invalid way:
    - Pick the lowest-numbered invalid way.
    - Write tag and set valid.
    - rsp_hit = 0, evict_valid = 0.
    - lru_access_o = 1 with that way.
  - op = 0, miss with all ways valid:
    - Way = lru_victim_i, sampled this cycle.
    - evict_tag = old tag, evict_valid = 1.
    - Overwrite the tag; valid stays 1.
    - lru_access_o = 1 with that way.
  - op = 1, hit:
    - Clear valid. rsp_hit = 1, rsp_way = way.
    - lru_update_o = 1, lru_index_o = way.
  - op = 1, miss:
    - No table change, no LRU strobe.
    - rsp_hit = 0, rsp_way = 0.
  - Always go to RESP.
- RESP:
  - rsp_valid_o = 1; all rsp_* fields come from registers and are stable while held.
  - On rsp_ready_i, go to IDLE.
  - Backpressure may last any number of cycles.
- LRU strobes:
  - Asserted only in LOOKUP and never both at once.
  - lru_index_o is held at 0 when no strobe is active.
- Latency and throughput:
  - Request accepted at cycle 0, LOOKUP in cycle 1, rsp_valid_o first high in cycle 2.
  - Best-case throughput is one request per 3 cycles. This guarantees the tracker's registered victim reflects the previous access before the next LOOKUP samples it.
- A request presented while not in IDLE is not accepted; the requester holds it.
- Reset values:
  - All valid bits 0, tags 0, state IDLE.
  - rsp_valid_o = 0 and all rsp_* fields 0.
  - lru_access_o = 0, lru_update_o = 0, lru_index_o = 0.
  - req_ready_o = 1 once rst_n deasserts.
- Reset mid-operation: an in-flight request or pending response is dropped without a response. The integrator resets the tracker from the same reset, polarity-adapted.

Decomposition:
- Package lru_alloc_pkg holds:
  - NUM_WAYS = 4 and WAY_W = 2;
  - state enum {IDLE, LOOKUP, RESP};
  - op enum {OP_LOOKUP, OP_INVAL}.
- One natural sub-module, lru_tag_match. It is combinational: 4-way tag compare, hit flag and encoded hit way, plus an any-invalid flag and lowest-invalid-way priority encoder.

Test Plan:
- Reset, then lookups for tags 0x11, 0x22, 0x33, 0x44 → misses allocated to ways 0, 1, 2, 3; evict_valid = 0; one lru_access_o pulse per request with index 0, 1, 2, 3.
- Table full, lookup 0x22 → hit, way 1, lru_access_o with index 1; table unchanged.
- Table full, tracker victim = 2, lookup 0x55 → miss, way 2, evict_valid = 1, evict_tag = 0x33; a later lookup of 0x33 misses.
- Invalidate 0x11 → hit, way 0, lru_update_o with index 0; then lookup 0x66 allocates way 0 with evict_valid = 0, ignoring the victim. Invalidate 0x99 → rsp_hit = 0, no strobe.
- Hold rsp_ready_i low for 5 cycles → rsp_valid_o and fields stable, req_ready_o = 0, a waiting request is not accepted; it is accepted in IDLE after the response handshake.
- Assert rst_n low during RESP → rsp_valid_o drops immediately, all valid bits clear; first lookup after reset allocates way 0.
